soc_out_pio: RTL and testbench
==============================

// Module: soc_out_pio
// PURPOSE
//   Avalon-MM slave PIO that drives output pins (LEDs, hex enables, strobes) from the CPU.
//   It complements the input-key PIO. The output register supports read/write, atomic
//   bit-set and bit-clear, and a hardware one-shot pulse with a programmable length.
//   It sits on the SoC's lightweight Avalon bus; out_port goes to board-level logic.
// PARAMETERS
//   WIDTH        8     number of output bits (1..32)
//   RESET_VALUE  0     DATA register value after reset
//   PLEN_W       16    width of the PULSE_LEN register and the pulse counter
// PORTS
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous, active-low reset
//   address     in   3      word address of the register
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe; a write occurs when chipselect && !write_n
//   writedata   in   32     write data; bits above WIDTH (or above PLEN_W) are ignored
//   readdata    out  32     registered read data; zero-extended
//   out_port    out  WIDTH  pin drive = data_q | pulse_mask_q
// BEHAVIOUR
//   Clocking and reset
//   - One clock domain. Reset is asynchronous and active-low.
//   - Reset values: data_q=RESET_VALUE, pulse_len_q=1, pulse_mask_q=0, cnt_q=0,
//     state=IDLE, readdata=0, out_port=RESET_VALUE.
//   Register map (address: access, function)
//   - 0 DATA      R/W  data_q
//   - 1 PULSE_LEN R/W  pulse_len_q[PLEN_W-1:0]
//   - 4 OUTSET    W    data_q <= data_q | wd
//   - 5 OUTCLEAR  W    data_q <= data_q & ~wd
//   - 6 PULSE     W    start a pulse on bits =1. Reads return pulse_mask_q.
//   - 2, 3, 7: reads return 0; writes are ignored. Writes to read-only fields are ignored.
//   Write and read timing
//   - All writes take effect at the clock edge that samples the write.
//   - out_port is combinational from the registers, so it changes in the same cycle as
//     the register update.
//   - readdata is updated on every clk with mux(address); it is not gated by a read
//     strobe. Read latency is 1 cycle.
//   Pulse FSM (states IDLE, PULSING)
//   - IDLE: a PULSE write with wd[WIDTH-1:0]!=0 performs
//       pulse_mask_q <= wd,
//       cnt_q <= max(pulse_len_q,1)-1,
//     then moves to PULSING. A PULSE write with zero data has no effect.
//   - PULSING: if cnt_q==0, clear pulse_mask_q and move to IDLE. Otherwise cnt_q decrements.
//   - Result: the pulsed bits are high for exactly max(PULSE_LEN,1) cycles.
//     PULSE_LEN=0 behaves as 1.
//   - PULSE write while PULSING: pulse_mask_q |= wd, cnt_q reloads, stays PULSING.
//     This restart takes priority over expiry in the same cycle.
//   - PULSE_LEN write while PULSING: the current count is unaffected; the new length
//     applies to the next load.
//   - The pulse never modifies data_q. A bit that is set in DATA stays high after the
//     pulse ends.
//   - DATA, OUTSET, or OUTCLEAR writes during a pulse update data_q normally.
//   - Reset mid-pulse: the mask clears immediately and out_port returns to RESET_VALUE.
//   Width rules
//   - cnt_q is PLEN_W bits and never underflows; it is only decremented when nonzero.
//   - Writedata bits at or above WIDTH are dropped, and read back as 0.
// TESTING
//   1. Reset (WIDTH=8, RESET_VALUE=8'hA5): out_port==8'hA5, readdata==0. Read addr0 ->
//      readdata==32'h000000A5 one cycle later.
//   2. Write DATA=8'h0F, OUTSET 8'h30, OUTCLEAR 8'h03 -> out_port sequence 0F, 3F, 3C;
//      readback of addr0 ==32'h3C.
//   3. PULSE_LEN=4, PULSE 8'h80 with DATA=0 -> out_port[7] high exactly 4 cycles; addr6
//      reads 80 during the pulse and 0 after it.
//   4. PULSE_LEN=0, PULSE 8'h01 -> out_port[0] high exactly 1 cycle.
//      PULSE 8'h00 -> no change, FSM stays IDLE.
//   5. PULSE_LEN=5, PULSE 8'h01, then PULSE 8'h02 3 cycles later -> bit0 high 8 cycles
//      total, bit1 high 5 cycles, and both drop in the same cycle.
//   6. Assert reset_n low on the 2nd cycle of a 10-cycle pulse -> out_port==RESET_VALUE
//      asynchronously. After release, the FSM is IDLE and addr6 reads 0.
//      Writes with chipselect=0 -> ignored.

Source files
------------

// File: rtl/soc_out_pio.sv
// ----------------------------------------------------------------------------
// soc_out_pio
//   Avalon-MM slave output PIO. Drives board-level output pins (LEDs, hex
//   enables, strobes) from the CPU. The output register supports plain
//   read/write, atomic bit-set and bit-clear, and a hardware one-shot pulse
//   whose length is programmable through PULSE_LEN.
//
//   Register map (word addresses):
//     0 DATA       R/W  data_q
//     1 PULSE_LEN  R/W  pulse_len_q
//     4 OUTSET     W    data_q |= wd
//     5 OUTCLEAR   W    data_q &= ~wd
//     6 PULSE      W    start/extend a pulse on bits set in wd; reads mask
//     2,3,7             read as 0, writes ignored
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe (write = chipselect && !write_n)
//   writedata   write data; bits above WIDTH / PLEN_W are dropped
//   readdata    registered read data, zero-extended, 1-cycle latency
//   out_port    pin drive = data_q | pulse_mask_q
//   state_dbg   pulse FSM state (0 = IDLE, 1 = PULSING)
//
// Bus handshake: there is no wait-request. A write is accepted on every clock
// edge where chipselect && !write_n; readdata is refreshed on every edge from
// the current address, independent of any read strobe.
// ----------------------------------------------------------------------------
module soc_out_pio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PLEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE    = 1'b0,
        PULSING = 1'b1
    } state_t;

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_PLEN     = 3'd1;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;
    localparam logic [2:0] A_PULSE    = 3'd6;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q;
    logic [PLEN_W-1:0] pulse_len_q;
    logic [WIDTH-1:0]  pulse_mask_q, mask_d;
    logic [PLEN_W-1:0] cnt_q, cnt_d;
    logic [PLEN_W-1:0] load_val;
    logic [31:0]       rd_d;

    logic              wr_en;
    logic              pulse_wr;
    logic [WIDTH-1:0]  wd;
    logic [PLEN_W-1:0] wd_len;

    // Upper writedata bits are intentionally discarded.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en    = chipselect && !write_n;
    assign wd       = writedata[WIDTH-1:0];
    assign wd_len   = writedata[PLEN_W-1:0];
    // A pulse write carrying no set bits is a no-op in every state.
    assign pulse_wr = wr_en && (address == A_PULSE) && (wd != '0);

    // Counter preload is max(len,1)-1 so the pulse lasts max(len,1) cycles:
    // the load edge itself is the first high cycle.
    assign load_val = (pulse_len_q == '0) ? '0 : pulse_len_q - PLEN_W'(1);

    assign out_port  = data_q | pulse_mask_q;
    assign state_dbg = state_q;

    // DATA and PULSE_LEN registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= RESET_VALUE;
            pulse_len_q <= PLEN_W'(1);
        end else if (wr_en) begin
            case (address)
                A_DATA:     data_q      <= wd;
                A_PLEN:     pulse_len_q <= wd_len;
                A_OUTSET:   data_q      <= data_q | wd;
                A_OUTCLEAR: data_q      <= data_q & ~wd;
                default:    ;
            endcase
        end
    end

    // Pulse FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pulse_mask_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pulse_mask_q <= mask_d;
            cnt_q        <= cnt_d;
        end
    end

    // Pulse FSM: next state. A restart outranks expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        mask_d  = pulse_mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pulse_wr) begin
                    mask_d  = wd;
                    cnt_d   = load_val;
                    state_d = PULSING;
                end
            end
            PULSING: begin
                if (pulse_wr) begin
                    mask_d = pulse_mask_q | wd;
                    cnt_d  = load_val;
                end else if (cnt_q == '0) begin
                    mask_d  = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - PLEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Read mux, registered every cycle
    always_comb begin
        rd_d = '0;
        case (address)
            A_DATA:  rd_d = 32'(data_q);
            A_PLEN:  rd_d = 32'(pulse_len_q);
            A_PULSE: rd_d = 32'(pulse_mask_q);
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_d;
        end
    end

endmodule

// File: tb/tb_soc_out_pio.sv
// ----------------------------------------------------------------------------
// tb_soc_out_pio
//   Self-checking bench for soc_out_pio (WIDTH=8, RESET_VALUE=8'hA5).
//   Inputs are driven at the falling edge; outputs are sampled at the next
//   falling edge, after the rising edge that consumed the bus cycle.
// ----------------------------------------------------------------------------
module tb_soc_out_pio;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RV    = 8'hA5;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        state_dbg;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];

    soc_out_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .PLEN_W      (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check(tag, obs, e);
    endtask

    // ---------------- driver ----------------
    // One bus cycle: drive now (at a falling edge), return at the next
    // falling edge with the rising edge's effects visible.
    task automatic bus(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi0;
        int hi1;
        int drop0;
        int drop1;

        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // 1. reset state and first readback
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_port), 32'(RV));
        check("rst_rd", readdata, 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        bus(3'd0, 1'b1, 1'b1, 32'h0);
        check("rd_data_rst", readdata, 32'h0000_00A5);
        bus(3'd1, 1'b1, 1'b1, 32'h0);
        check("rd_plen_rst", readdata, 32'h1);

        // 2. DATA / OUTSET / OUTCLEAR
        sb_push(32'h0F); bus(3'd0, 1'b1, 1'b0, 32'h0F); sb_pop("t2_data", 32'(out_port));
        sb_push(32'h3F); bus(3'd4, 1'b1, 1'b0, 32'h30); sb_pop("t2_set", 32'(out_port));
        sb_push(32'h3C); bus(3'd5, 1'b1, 1'b0, 32'h03); sb_pop("t2_clr", 32'(out_port));
        sb_push(32'h3C); bus(3'd0, 1'b1, 1'b1, 32'h0);  sb_pop("t2_rd", readdata);

        // 3. PULSE_LEN=4, pulse bit7
        bus(3'd0, 1'b1, 1'b0, 32'h0);
        bus(3'd1, 1'b1, 1'b0, 32'h4);
        bus(3'd1, 1'b1, 1'b1, 32'h0);
        check("t3_plen_rd", readdata, 32'h4);
        hi0 = 0;
        for (int i = 0; i < 8; i++) begin
            sb_push((i < 4) ? 32'h80 : 32'h00);
            if (i == 0) bus(3'd6, 1'b1, 1'b0, 32'h80);
            else        bus(3'd6, 1'b1, 1'b1, 32'h0);
            if (out_port[7]) hi0++;
            sb_pop("t3_out", 32'(out_port));
            if (i == 2) check("t3_rd_mid", readdata, 32'h80);
        end
        check("t3_rd_after", readdata, 32'h0);
        check("t3_high_cycles", 32'(hi0), 32'd4);

        // 4. PULSE_LEN=0 behaves as 1; zero pulse write is a no-op
        bus(3'd1, 1'b1, 1'b0, 32'h0);
        hi0 = 0;
        for (int i = 0; i < 4; i++) begin
            sb_push((i < 1) ? 32'h01 : 32'h00);
            if (i == 0) bus(3'd6, 1'b1, 1'b0, 32'h01);
            else        bus(3'd6, 1'b1, 1'b1, 32'h0);
            if (out_port[0]) hi0++;
            sb_pop("t4_out", 32'(out_port));
        end
        check("t4_high_cycles", 32'(hi0), 32'd1);
        bus(3'd6, 1'b1, 1'b0, 32'h00);
        check("t4_zero_out", 32'(out_port), 32'h0);
        check("t4_zero_state", 32'(state_dbg), 32'h0);
        bus(3'd6, 1'b1, 1'b1, 32'h0);
        check("t4_zero_rd", readdata, 32'h0);

        // 5. restart mid-pulse: bit0 8 cycles, bit1 5 cycles, common drop
        bus(3'd1, 1'b1, 1'b0, 32'h5);
        hi0 = 0; hi1 = 0; drop0 = -1; drop1 = -1;
        for (int i = 0; i < 11; i++) begin
            logic [7:0] e;
            e = 8'h00;
            if (i < 8) e[0] = 1'b1;
            if (i >= 3 && i < 8) e[1] = 1'b1;
            sb_push(32'(e));
            if (i == 0)      bus(3'd6, 1'b1, 1'b0, 32'h01);
            else if (i == 3) bus(3'd6, 1'b1, 1'b0, 32'h02);
            else             bus(3'd6, 1'b1, 1'b1, 32'h0);
            if (out_port[0]) hi0++;
            if (out_port[1]) hi1++;
            if (!out_port[0] && drop0 < 0) drop0 = i;
            if (!out_port[1] && i >= 3 && drop1 < 0) drop1 = i;
            sb_pop("t5_out", 32'(out_port));
        end
        check("t5_bit0_cycles", 32'(hi0), 32'd8);
        check("t5_bit1_cycles", 32'(hi1), 32'd5);
        check("t5_bit0_drop", 32'(drop0), 32'd8);
        check("t5_bit1_drop", 32'(drop1), 32'd8);

        // 6. reset mid-pulse, then chipselect=0 writes ignored
        bus(3'd1, 1'b1, 1'b0, 32'd10);
        bus(3'd6, 1'b1, 1'b0, 32'h04);
        check("t6_pulse_on", 32'(out_port), 32'h04);
        bus(3'd6, 1'b1, 1'b1, 32'h0);
        check("t6_pulse_2nd", 32'(out_port), 32'h04);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_out", 32'(out_port), 32'(RV));
        check("t6_async_state", 32'(state_dbg), 32'h0);
        check("t6_async_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus(3'd6, 1'b1, 1'b1, 32'h0);
        check("t6_mask_rd", readdata, 32'h0);
        check("t6_state_idle", 32'(state_dbg), 32'h0);
        check("t6_out_rv", 32'(out_port), 32'(RV));
        bus(3'd0, 1'b0, 1'b0, 32'h11);
        bus(3'd6, 1'b0, 1'b0, 32'hFF);
        check("t6_cs0_out", 32'(out_port), 32'(RV));
        check("t6_cs0_state", 32'(state_dbg), 32'h0);
        bus(3'd0, 1'b1, 1'b1, 32'h0);
        check("t6_cs0_rd", readdata, 32'h0000_00A5);

        // width rules and unused addresses
        bus(3'd0, 1'b1, 1'b0, 32'hFFFF_FF5A);
        check("w_out", 32'(out_port), 32'h5A);
        bus(3'd0, 1'b1, 1'b1, 32'h0);
        check("w_rd", readdata, 32'h0000_005A);
        bus(3'd1, 1'b1, 1'b0, 32'hABCD_1234);
        bus(3'd1, 1'b1, 1'b1, 32'h0);
        check("w_plen_rd", readdata, 32'h0000_1234);
        bus(3'd2, 1'b1, 1'b0, 32'hFF);
        bus(3'd2, 1'b1, 1'b1, 32'h0);
        check("a2_rd", readdata, 32'h0);
        check("a2_out", 32'(out_port), 32'h5A);
        bus(3'd7, 1'b1, 1'b1, 32'h0);
        check("a7_rd", readdata, 32'h0);

        if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
